// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and hazard_ctrl: the D-stage descriptor and
// the E/M status flow in, and the pipeline control strobes and forwarding selects flow out.
interface hazard_ctrl_if #(
  parameter int REG_AW = 5
);
  logic              d_valid, d_use_rs1, d_use_rs2, d_wr, d_load, d_long;
  logic [REG_AW-1:0] d_rs1, d_rs2, d_rd;
  logic              e_redirect, m_ready;
  logic              fd_hold, e_hold, e_bubble, m_bubble, d_flush;
  logic [1:0]        e_rs1_sel, e_rs2_sel;
  logic [REG_AW-1:0] w_rd;
  logic              w_we;

  modport master (
    output d_valid, d_use_rs1, d_use_rs2, d_wr, d_load, d_long,
    output d_rs1, d_rs2, d_rd, e_redirect, m_ready,
    input  fd_hold, e_hold, e_bubble, m_bubble, d_flush,
    input  e_rs1_sel, e_rs2_sel, w_rd, w_we
  );

  modport slave (
    input  d_valid, d_use_rs1, d_use_rs2, d_wr, d_load, d_long,
    input  d_rs1, d_rs2, d_rd, e_redirect, m_ready,
    output fd_hold, e_hold, e_bubble, m_bubble, d_flush,
    output e_rs1_sel, e_rs2_sel, w_rd, w_we
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for an in-order D/E/M/W pipeline: stalls, bubbles, flushes, forwarding selects.
// Define HAZARD_CTRL_FWD_EN for E-stage operand forwarding; otherwise RAW hazards stall in D.
module hazard_ctrl #(
  parameter int REG_AW  = 5,
  parameter int MUL_LAT = 3
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave bus
);
  localparam int CNT_W = 3;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              wr;
    logic              load;
    logic              lng;
  } stg_t;

  typedef struct packed {
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              use1;
    logic              use2;
  } src_t;

  logic             r_vld_p0, r_vld_p1, r_vld_p2;
  stg_t             r_e_p0, r_m_p1, r_w_p2;
  src_t             r_src_p0;
  logic [CNT_W-1:0] r_busy_cnt;
  logic             r_redir_pend;

  logic [REG_AW-1:0] w_rs1m, w_rs2m;
  logic w_m_wait, w_busy, w_redir, w_redir_e, w_hit_e, w_hit_m;
  logic w_ld_use, w_raw, w_d_stall, w_unused;

  function automatic logic rd_hit(input logic [REG_AW-1:0] rd,
                                  input logic [REG_AW-1:0] a,
                                  input logic [REG_AW-1:0] b);
    return (rd != '0) && ((rd == a) || (rd == b));
  endfunction

  // Unused D sources are masked to x0 so they can never match a nonzero rd.
  assign w_rs1m  = bus.d_use_rs1 ? bus.d_rs1 : '0;
  assign w_rs2m  = bus.d_use_rs2 ? bus.d_rs2 : '0;
  assign w_hit_e = bus.d_valid & rd_hit(r_e_p0.rd, w_rs1m, w_rs2m);
  assign w_hit_m = bus.d_valid & rd_hit(r_m_p1.rd, w_rs1m, w_rs2m);

  assign w_m_wait  = r_vld_p1 & ~bus.m_ready;
  assign w_busy    = (r_busy_cnt != '0);
  assign w_redir_e = bus.e_redirect & r_vld_p0;
  assign w_redir   = w_redir_e | r_redir_pend;
  assign w_ld_use  = r_vld_p0 & r_e_p0.load & w_hit_e;
  assign w_d_stall = w_ld_use | w_raw;

`ifdef HAZARD_CTRL_FWD_EN
  function automatic logic [1:0] fwd_sel(input logic use_b, input logic [REG_AW-1:0] rs);
    if (!r_vld_p0 || !use_b || rs == '0) return 2'd0;
    if (r_vld_p1 && r_m_p1.wr && r_m_p1.rd == rs) return 2'd1;
    if (r_vld_p2 && r_w_p2.wr && r_w_p2.rd == rs) return 2'd2;
    return 2'd0;
  endfunction

  assign bus.e_rs1_sel = fwd_sel(r_src_p0.use1, r_src_p0.rs1);
  assign bus.e_rs2_sel = fwd_sel(r_src_p0.use2, r_src_p0.rs2);
  assign w_raw         = 1'b0;
`else
  // No bypass network: the register file writes through, so only E and M producers stall D.
  assign bus.e_rs1_sel = 2'd0;
  assign bus.e_rs2_sel = 2'd0;
  assign w_raw         = (r_vld_p0 & r_e_p0.wr & w_hit_e) | (r_vld_p1 & r_m_p1.wr & w_hit_m);
`endif

  assign bus.w_rd = r_w_p2.rd;
  assign bus.w_we = r_vld_p2 & r_w_p2.wr & (r_w_p2.rd != '0);

  assign w_unused = ^{r_e_p0.wr, r_e_p0.lng, r_m_p1.load, r_m_p1.lng,
                      r_w_p2.load, r_w_p2.lng, r_src_p0, w_hit_m};

  always_comb begin
    bus.fd_hold  = 1'b0;
    bus.e_hold   = 1'b0;
    bus.e_bubble = 1'b0;
    bus.m_bubble = 1'b0;
    bus.d_flush  = 1'b0;
    if (w_m_wait) begin
      bus.fd_hold = 1'b1;
      bus.e_hold  = 1'b1;
    end else if (w_busy) begin
      bus.fd_hold  = 1'b1;
      bus.e_hold   = 1'b1;
      bus.m_bubble = 1'b1;
    end else if (w_redir) begin
      bus.d_flush  = 1'b1;
      bus.e_bubble = 1'b1;
    end else if (w_d_stall) begin
      bus.fd_hold  = 1'b1;
      bus.e_bubble = 1'b1;
    end
  end

  // Stage boundaries: D -> E (p0) -> M (p1) -> W (p2)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p0     <= 1'b0;
      r_vld_p1     <= 1'b0;
      r_vld_p2     <= 1'b0;
      r_e_p0       <= '0;
      r_m_p1       <= '0;
      r_w_p2       <= '0;
      r_src_p0     <= '0;
      r_busy_cnt   <= '0;
      r_redir_pend <= 1'b0;
    end else if (w_m_wait) begin
      r_vld_p2 <= 1'b0;
      if (w_redir_e) r_redir_pend <= 1'b1;
    end else if (w_busy) begin
      r_busy_cnt <= r_busy_cnt - 1'b1;
      r_vld_p1   <= 1'b0;
      r_vld_p2   <= r_vld_p1;
      r_w_p2     <= r_m_p1;
      if (w_redir_e) r_redir_pend <= 1'b1;
    end else begin
      r_vld_p1     <= r_vld_p0;
      r_m_p1       <= r_e_p0;
      r_vld_p2     <= r_vld_p1;
      r_w_p2       <= r_m_p1;
      r_redir_pend <= 1'b0;
      if (w_redir || w_d_stall || !bus.d_valid) begin
        r_vld_p0 <= 1'b0;
      end else begin
        r_vld_p0 <= 1'b1;
        r_e_p0   <= '{rd: bus.d_rd, wr: bus.d_wr, load: bus.d_load, lng: bus.d_long};
        r_src_p0 <= '{rs1: bus.d_rs1, rs2: bus.d_rs2, use1: bus.d_use_rs1, use2: bus.d_use_rs2};
        if (bus.d_long) r_busy_cnt <= CNT_W'(MUL_LAT - 1);
      end
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed pipeline scenarios then random traffic, each cycle checked
// against an instruction-level model of the pipeline kept in this file.
module tb_hazard_ctrl;
  localparam int REG_AW  = 5;
  localparam int MUL_LAT = 4;
`ifdef HAZARD_CTRL_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_AW(REG_AW)) bus ();
  hazard_ctrl #(.REG_AW(REG_AW), .MUL_LAT(MUL_LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    bit v;
    int rd, rs1, rs2;
    bit u1, u2, wr, ld, lg;
  } ins_t;

  ins_t m_e, m_m, m_w, dq, nop;
  int   e_age;        // cycles the E instruction has spent executing (m_wait cycles excluded)
  bit   redir_seen;   // redirect already requested by the instruction now in E
  bit   in_redir, in_mrdy;
  int   n_chk = 0, n_err = 0;
  int   obs_fd, obs_eh, obs_eb, obs_mb, obs_fl, obs_we, obs_wrd, obs_s1, obs_s2;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic ins_t mk(input int rd, input int rs1, input bit u1, input int rs2,
                              input bit u2, input bit wr, input bit ld, input bit lg);
    ins_t i;
    i.v = 1'b1; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2;
    i.u1 = u1; i.u2 = u2; i.wr = wr; i.ld = ld; i.lg = lg;
    return i;
  endfunction

  function automatic bit reads(input int r);
    return dq.v && r != 0 && ((dq.u1 && dq.rs1 == r) || (dq.u2 && dq.rs2 == r));
  endfunction

  function automatic int fwd(input bit u, input int rs);
    if (!m_e.v || !u || rs == 0) return 0;
    if (m_m.v && m_m.wr && m_m.rd == rs) return 1;
    if (m_w.v && m_w.wr && m_w.rd == rs) return 2;
    return 0;
  endfunction

  task automatic drive(input ins_t i, input bit redir, input bit mrdy);
    dq = i;
    in_redir = redir;
    in_mrdy  = mrdy;
    bus.d_valid = i.v;   bus.d_use_rs1 = i.u1;  bus.d_use_rs2 = i.u2;
    bus.d_wr    = i.wr;  bus.d_load    = i.ld;  bus.d_long    = i.lg;
    bus.d_rd    = REG_AW'(i.rd);
    bus.d_rs1   = REG_AW'(i.rs1);
    bus.d_rs2   = REG_AW'(i.rs2);
    bus.e_redirect = redir;
    bus.m_ready    = mrdy;
  endtask

  // One clock: check outputs mid-cycle against the model, then move the model one cycle on.
  task automatic cycle();
    bit mwait, busy, redir, dst;
    int x_fd, x_eh, x_eb, x_mb, x_fl, x_we;
    @(negedge clk);
    mwait = m_m.v && !in_mrdy;
    busy  = m_e.v && m_e.lg && (e_age < MUL_LAT - 1);
    redir = m_e.v && (in_redir || redir_seen);
    dst   = m_e.v && m_e.ld && reads(m_e.rd);
    if (!FWD) dst = dst || (m_e.v && m_e.wr && reads(m_e.rd)) || (m_m.v && m_m.wr && reads(m_m.rd));
    x_fd = 0; x_eh = 0; x_eb = 0; x_mb = 0; x_fl = 0;
    if (mwait) begin x_fd = 1; x_eh = 1; end
    else if (busy) begin x_fd = 1; x_eh = 1; x_mb = 1; end
    else if (redir) begin x_fl = 1; x_eb = 1; end
    else if (dst) begin x_fd = 1; x_eb = 1; end
    x_we = (m_w.v && m_w.wr && m_w.rd != 0) ? 1 : 0;

    obs_fd = int'(bus.fd_hold);  obs_eh = int'(bus.e_hold);  obs_eb = int'(bus.e_bubble);
    obs_mb = int'(bus.m_bubble); obs_fl = int'(bus.d_flush); obs_we = int'(bus.w_we);
    obs_wrd = int'(bus.w_rd);    obs_s1 = int'(bus.e_rs1_sel); obs_s2 = int'(bus.e_rs2_sel);
    chk("fd_hold", obs_fd, x_fd);
    chk("e_hold", obs_eh, x_eh);
    chk("e_bubble", obs_eb, x_eb);
    chk("m_bubble", obs_mb, x_mb);
    chk("d_flush", obs_fl, x_fl);
    chk("w_we", obs_we, x_we);
    chk("e_rs1_sel", obs_s1, FWD ? fwd(m_e.u1, m_e.rs1) : 0);
    chk("e_rs2_sel", obs_s2, FWD ? fwd(m_e.u2, m_e.rs2) : 0);
    if (x_we == 1) chk("w_rd", obs_wrd, m_w.rd);

    if (rst) begin
      m_e.v = 0; m_m.v = 0; m_w.v = 0; e_age = 0; redir_seen = 0;
    end else if (mwait) begin
      m_w.v = 0;
      if (m_e.v && in_redir) redir_seen = 1;
    end else if (busy) begin
      m_w = m_m; m_m.v = 0; e_age++;
      if (m_e.v && in_redir) redir_seen = 1;
    end else begin
      m_w = m_m; m_m = m_e; m_e = dq;
      if (redir || dst) m_e.v = 0;
      e_age = 0; redir_seen = 0;
    end
    @(posedge clk);
    #1;
  endtask

  // Present an instruction in D until the pipeline takes (or flushes) it.
  task automatic issue(input ins_t i, output int holds, output int mbs);
    bit done;
    holds = 0; mbs = 0; done = 0;
    drive(i, 1'b0, 1'b1);
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (obs_fd == 0) begin
        done = 1;
        break;
      end
      holds++;
      if (obs_mb == 1) mbs++;
    end
    chk("issue_accepted", int'(done), 1);
    drive(nop, 1'b0, 1'b1);
  endtask

  task automatic drain();
    drive(nop, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) cycle();
  endtask

  initial begin
    int   h, mb, held, fl;
    ins_t r;
    nop = '{default: 0};
    m_e = nop; m_m = nop; m_w = nop; e_age = 0; redir_seen = 0;
    rst = 1'b1;
    drive(nop, 1'b0, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    cycle();
    rst = 1'b0;
    cycle();
    chk("rst_fd_hold", obs_fd, 0);
    chk("rst_d_flush", obs_fl, 0);
    chk("rst_w_we", obs_we, 0);
    chk("rst_w_rd", obs_wrd, 0);

    // add x5 then dependent add x6,x5,x5
    issue(mk(5, 1, 1, 2, 1, 1, 0, 0), h, mb);
    issue(mk(6, 5, 1, 5, 1, 1, 0, 0), h, mb);
    chk("b2b_holds", h, FWD ? 0 : 2);
    cycle();
    chk("b2b_rs1_sel", obs_s1, FWD ? 1 : 0);
    chk("b2b_rs2_sel", obs_s2, FWD ? 1 : 0);

    // add x5 then sub x6,x5,x1
    drain();
    issue(mk(5, 1, 1, 2, 1, 1, 0, 0), h, mb);
    issue(mk(6, 5, 1, 1, 1, 1, 0, 0), h, mb);
    chk("sub_holds", h, FWD ? 0 : 2);
    cycle();
    chk("sub_rs1_sel", obs_s1, FWD ? 1 : 0);
    chk("sub_rs2_sel", obs_s2, 0);

    // ld x7 then add x8,x7,x0
    drain();
    issue(mk(7, 2, 1, 0, 0, 1, 1, 0), h, mb);
    issue(mk(8, 7, 1, 0, 1, 1, 0, 0), h, mb);
    chk("ldu_holds", h, FWD ? 1 : 2);
    cycle();
    chk("ldu_rs1_sel", obs_s1, FWD ? 2 : 0);
    chk("ldu_rs2_sel", obs_s2, 0);

    // long op (MUL_LAT = 4) then independent add
    drain();
    issue(mk(9, 1, 1, 2, 1, 1, 0, 1), h, mb);
    issue(mk(10, 3, 1, 4, 1, 1, 0, 0), h, mb);
    chk("long_holds", h, 3);
    chk("long_m_bubbles", mb, 3);

    // ld stalled in M for 5 cycles while the branch in E redirects
    drain();
    issue(mk(3, 1, 1, 0, 0, 1, 1, 0), h, mb);
    issue(mk(0, 2, 1, 0, 0, 0, 0, 0), h, mb);
    held = 0; fl = 0;
    for (int k = 0; k < 5; k++) begin
      drive(mk(11, 12, 1, 13, 1, 1, 0, 0), (k == 0), 1'b0);
      cycle();
      held += obs_fd & obs_eh;
      fl   += obs_fl;
    end
    chk("mwait_held", held, 5);
    chk("mwait_flush", fl, 0);
    drive(mk(11, 12, 1, 13, 1, 1, 0, 0), 1'b0, 1'b1);
    cycle();
    chk("redir_flush", obs_fl, 1);
    chk("redir_bubble", obs_eb, 1);
    chk("redir_fd_hold", obs_fd, 0);

    // reset in the middle of a long-op hold
    drain();
    issue(mk(13, 1, 1, 2, 1, 1, 0, 1), h, mb);
    drive(mk(14, 1, 1, 2, 1, 1, 0, 0), 1'b0, 1'b1);
    cycle();
    chk("pre_rst_hold", obs_fd, 1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    chk("post_rst_fd_hold", obs_fd, 0);
    chk("post_rst_e_hold", obs_eh, 0);
    chk("post_rst_e_bubble", obs_eb, 0);
    chk("post_rst_m_bubble", obs_mb, 0);
    chk("post_rst_d_flush", obs_fl, 0);
    chk("post_rst_w_we", obs_we, 0);
    chk("post_rst_w_rd", obs_wrd, 0);
    chk("post_rst_rs1_sel", obs_s1, 0);
    chk("post_rst_rs2_sel", obs_s2, 0);

    // random traffic over a small register window so hazards are frequent
    for (int c = 0; c < 800; c++) begin
      r = mk($urandom_range(0, 7), $urandom_range(0, 7), ($urandom_range(0, 3) != 0),
             $urandom_range(0, 7), ($urandom_range(0, 1) == 1), ($urandom_range(0, 4) != 0),
             1'b0, 1'b0);
      r.v = ($urandom_range(0, 9) < 8);
      case ($urandom_range(0, 9))
        0, 1:    r.ld = 1'b1;
        2:       r.lg = 1'b1;
        default: ;
      endcase
      rst = ($urandom_range(0, 149) == 0);
      drive(r, ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) != 0));
      cycle();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
